// File: rtl/tpu_pkg.sv
// tpu_pkg: shared FSM state encoding and accumulator width helper for the
// matrix-multiply core and its PE grid.
`default_nettype none

package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    // Full-precision sum of n products of two dw-bit operands.
    function automatic int accw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_array.sv
// pe_array: NxN output-stationary MAC grid; A flows left-to-right, B flows
// top-to-bottom, each PE keeps its own accumulator.
`default_nettype none

module pe_array
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    parameter int ACCW   = accw(N, DW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [N*DW-1:0]        a_edge,
    input  logic [N*DW-1:0]        b_edge,
    output logic [N*N*ACCW-1:0]    acc_flat
);

    logic [DW-1:0] a_w [N][N];
    logic [DW-1:0] b_w [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]          a_in;
            logic [DW-1:0]          b_in;
            logic [DW-1:0]          a_q;
            logic [DW-1:0]          b_q;
            logic [ACCW-1:0]        acc_q;
            logic signed [DW:0]     a_x;
            logic signed [DW:0]     b_x;
            logic signed [2*DW+1:0] prod;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i*DW +: DW];
            end else begin : g_a_pass
                assign a_in = a_w[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j*DW +: DW];
            end else begin : g_b_pass
                assign b_in = b_w[i-1][j];
            end

            // One extra bit lets a single signed multiplier serve both modes.
            assign a_x  = (SIGNED != 0) ? {a_in[DW-1], a_in} : {1'b0, a_in};
            assign b_x  = (SIGNED != 0) ? {b_in[DW-1], b_in} : {1'b0, b_in};
            assign prod = a_x * b_x;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (en) begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_q + ACCW'(prod);
                end
            end

            assign a_w[i][j] = a_q;
            assign b_w[i][j] = b_q;
            assign acc_flat[(i*N+j)*ACCW +: ACCW] = acc_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmu_core_n.sv
// mmu_core_n: streaming NxN matrix multiply with optional transpose, ReLU and
// saturation; loads 2*N*N operand bytes, emits N*N result bytes row-major.
`default_nettype none

module mmu_core_n
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          transpose,
    input  logic          activation,
    input  logic          sat_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int NN    = N * N;
    localparam int TOT   = 2 * NN;
    localparam int ACCW  = accw(N, DW);
    localparam int LW    = $clog2(TOT + 1);
    localparam int AW    = $clog2(TOT);
    localparam int OW    = $clog2(NN);
    localparam int CW    = $clog2(3 * N - 1);
    localparam int CLAST = 3 * N - 2;

    state_e          state_q, state_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [CW-1:0]   ccnt_q;
    logic [OW-1:0]   ocnt_q;
    logic [DW-1:0]   buf_q [TOT];
    logic [DW-1:0]   res_q [NN];
    logic            trans_q, act_q, sat_q;

    logic            accept;
    logic [N*DW-1:0] a_edge, b_edge;
    logic [NN*ACCW-1:0] acc_flat;

    assign in_ready  = (lcnt_q < LW'(TOT)) && (state_q != ST_COMPUTE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_last  = out_valid && (ocnt_q == OW'(NN - 1));
    assign out_data  = out_valid ? res_q[ocnt_q] : '0;
    assign done      = out_last && out_ready;
    assign busy      = (state_q != ST_IDLE);

    function automatic logic [DW-1:0] post(input logic [ACCW-1:0] v,
                                           input logic act, input logic sat);
        logic [ACCW-1:0] x;
        logic [DW-1:0]   r;
        x = v;
        if ((SIGNED != 0) && act && x[ACCW-1])
            x = '0;
        r = x[DW-1:0];
        if (sat) begin
            if (SIGNED != 0) begin
                // Out of range when the bits above the DW-bit sign are not a pure sign extension.
                if (!(&x[ACCW-1:DW-1]) && (|x[ACCW-1:DW-1]))
                    r = x[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end else if (|x[ACCW-1:DW]) begin
                r = '1;
            end
        end
        return r;
    endfunction

    // Skewed feed: row i / column j see operand index k = ccnt - i (or - j).
    always_comb begin
        int k;
        k      = 0;
        a_edge = '0;
        b_edge = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ccnt_q) - i;
            if (state_q == ST_COMPUTE && k >= 0 && k < N) begin
                a_edge[i*DW +: DW] = buf_q[i*N + k];
                b_edge[i*DW +: DW] = trans_q ? buf_q[NN + i*N + k] : buf_q[NN + k*N + i];
            end
        end
    end

    pe_array #(
        .N      (N),
        .DW     (DW),
        .SIGNED (SIGNED),
        .ACCW   (ACCW)
    ) u_pe_array (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q != ST_COMPUTE),
        .en       (state_q == ST_COMPUTE),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .acc_flat (acc_flat)
    );

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE:    if (lcnt_q == LW'(TOT)) state_d = ST_COMPUTE;
            ST_COMPUTE: if (ccnt_q == CW'(CLAST)) state_d = ST_OUTPUT;
            ST_OUTPUT:  if (done) state_d = (lcnt_q == LW'(TOT)) ? ST_COMPUTE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (state_d == ST_COMPUTE && state_q != ST_COMPUTE)
            lcnt_d = '0;
        else if (accept)
            lcnt_d = lcnt_q + LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            ccnt_q  <= '0;
            ocnt_q  <= '0;
            trans_q <= 1'b0;
            act_q   <= 1'b0;
            sat_q   <= 1'b0;
            for (int e = 0; e < TOT; e++) buf_q[e] <= '0;
            for (int e = 0; e < NN; e++)  res_q[e] <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            ccnt_q  <= (state_q == ST_COMPUTE) ? ccnt_q + CW'(1) : '0;

            if (accept) begin
                buf_q[lcnt_q[AW-1:0]] <= in_data;
                if (lcnt_q == '0) begin
                    trans_q <= transpose;
                    act_q   <= activation;
                    sat_q   <= sat_en;
                end
            end

            // Post-processing happens at copy time so a job loaded during
            // OUTPUT cannot change the modes of results already queued.
            if (state_q == ST_COMPUTE && ccnt_q == CW'(CLAST))
                for (int e = 0; e < NN; e++)
                    res_q[e] <= post(acc_flat[e*ACCW +: ACCW], act_q, sat_q);

            if (state_q != ST_OUTPUT)
                ocnt_q <= '0;
            else if (out_ready)
                ocnt_q <= out_last ? '0 : ocnt_q + OW'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmu_core_n.sv
// tb_mmu_core_n: directed self-checking bench; an unsigned and a signed core
// share stimulus, and use_s selects which one is being checked.
`default_nettype none

module tb_mmu_core_n;

    logic       clk = 1'b0;
    logic       rst, in_valid, transpose, activation, sat_en, out_ready;
    logic [7:0] in_data;
    logic       use_s;

    wire        in_ready_u, out_valid_u, out_last_u, busy_u, done_u;
    wire [7:0]  out_data_u;
    wire        in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
    wire [7:0]  out_data_s;

    wire        o_in_ready = use_s ? in_ready_s  : in_ready_u;
    wire        o_valid    = use_s ? out_valid_s : out_valid_u;
    wire        o_last     = use_s ? out_last_s  : out_last_u;
    wire        o_busy     = use_s ? busy_s      : busy_u;
    wire        o_done     = use_s ? done_s      : done_u;
    wire [7:0]  o_data     = use_s ? out_data_s  : out_data_u;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmu_core_n #(.N(2), .DW(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .transpose(transpose), .activation(activation),
        .sat_en(sat_en), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_last(out_last_u), .busy(busy_u), .done(done_u)
    );

    mmu_core_n #(.N(2), .DW(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .transpose(transpose), .activation(activation),
        .sat_en(sat_en), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_last(out_last_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; modes are driven only with byte 0.
    task automatic send_job(input logic [63:0] v, input logic t, input logic a, input logic s);
        for (int i = 0; i < 8; i++) begin
            bit ok;
            int tries;
            ok    = 1'b0;
            tries = 0;
            in_valid   = 1'b1;
            in_data    = v[i*8 +: 8];
            transpose  = (i == 0) ? t : 1'b0;
            activation = (i == 0) ? a : 1'b0;
            sat_en     = (i == 0) ? s : 1'b0;
            while (!ok && tries < 50) begin
                ok = o_in_ready;
                @(posedge clk);
                @(negedge clk);
                tries++;
            end
            check($sformatf("byte_accepted[%0d]", i), ok, 1);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 40);
    endtask

    // Drains elements first..3 with out_ready high; returns at the negedge
    // after the final handshake.
    task automatic collect(input logic [31:0] exp, input int first);
        for (int idx = first; idx < 4; idx++) begin
            int w;
            w = 0;
            out_ready = 1'b1;
            while (!o_valid && w < 40) begin
                @(posedge clk);
                @(negedge clk);
                w++;
            end
            check($sformatf("valid[%0d]", idx), o_valid, 1);
            check($sformatf("data[%0d]", idx), o_data, exp[idx*8 +: 8]);
            check($sformatf("last[%0d]", idx), o_last, (idx == 3));
            check($sformatf("done[%0d]", idx), o_done, (idx == 3));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; transpose = 1'b0;
        activation = 1'b0; sat_en = 1'b0; out_ready = 1'b0; use_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", o_valid, 0);
        check("rst_out_data", o_data, 0);
        check("rst_out_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_in_ready", o_in_ready, 1);

        // Basic A x B with latency from the last operand byte.
        send_job(64'h08070605_04030201, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        check("latency", n, 6);
        collect(32'h322B1613, 0);

        // A x B^T.
        send_job(64'h08070605_04030201, 1'b1, 1'b0, 1'b0);
        wait_valid(n);
        collect(32'h35271711, 0);

        // All 255: saturated vs truncated.
        send_job(64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        collect(32'hFFFFFFFF, 0);
        send_job(64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        collect(32'h02020202, 0);

        // Signed core: -5,0,0,5 without ReLU, 0,0,0,5 with ReLU.
        use_s = 1'b1;
        send_job(64'h05000005_010000FF, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        collect(32'h050000FB, 0);
        send_job(64'h05000005_010000FF, 1'b0, 1'b1, 1'b1);
        wait_valid(n);
        collect(32'h05000000, 0);
        use_s = 1'b0;

        // Backpressure mid-stream, next job loaded during OUTPUT.
        send_job(64'h08070605_04030201, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        out_ready = 1'b1;
        check("stall_first", o_data, 19);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_valid[%0d]", c), o_valid, 1);
            check($sformatf("stall_data[%0d]", c), o_data, 22);
            check($sformatf("stall_last[%0d]", c), o_last, 0);
            @(posedge clk);
            @(negedge clk);
        end
        send_job(64'h08070605_04030201, 1'b1, 1'b0, 1'b0);
        check("full_in_ready", o_in_ready, 0);
        check("stall_data_after_load", o_data, 22);
        collect(32'h322B1613, 1);
        check("post_done_busy", o_busy, 1);
        check("post_done_in_ready", o_in_ready, 0);
        check("post_done_valid", o_valid, 0);
        wait_valid(n);
        check("back_to_back_latency", n, 5);
        collect(32'h35271711, 0);

        // Reset during the second COMPUTE cycle abandons the job.
        send_job(64'h08070605_04030201, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("compute_busy", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", o_busy, 0);
        check("midrst_in_ready", o_in_ready, 1);
        check("midrst_valid", o_valid, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid || o_done) seen = 1'b1;
        end
        check("midrst_no_output", seen, 0);
        send_job(64'h08070605_04030201, 1'b0, 1'b0, 1'b0);
        wait_valid(n);
        check("fresh_latency", n, 6);
        collect(32'h322B1613, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
